// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types and default configuration constants for the
//               data memory controller (FSM state encoding, parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;
   localparam int DEPTH_DEF  = 256;
   localparam int RD_LAT_DEF = 1;

   // Controller FSM: one outstanding request, reads park in RD_RESP until consumed
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } state_e;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : Single-port word storage with per-byte write enables and a
//               registered read. A read issued together with a write to the
//               same (shared) address returns the merged, newly written word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic                       we_i,
   input  logic [DATA_W/8-1:0]        be_i,
   input  logic [$clog2(DEPTH)-1:0]   addr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic                       re_i,
   output logic [DATA_W-1:0]          rdata_o
);

   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Write-first view of the addressed word: enabled bytes come from wdata_i
   always_comb begin
      rdata_d = mem_q[addr_i];
      for (int b = 0; b < BE_W; b++) begin
         if (we_i && be_i[b]) begin
            rdata_d[b*8 +: 8] = wdata_i[b*8 +: 8];
         end
      end
   end

   // Byte-lane writes and registered read; contents are never reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++) begin
         if (we_i && be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Request/response controller around data_mem_array. Accepts one
//               request at a time in IDLE, writes commit at the acceptance edge
//               (WrDone next cycle), reads return after RD_LAT cycles and are
//               held until RdReady. Read+write together is write-first.
//               Optional range check: define DATA_MEM_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 MemRead,
   input  logic                 MemWrite,
   input  logic [ADDR_W-1:0]    Address,
   input  logic [DATA_W-1:0]    WriteData,
   input  logic [DATA_W/8-1:0]  ByteEn,
   output logic                 ReqReady,
   output logic [DATA_W-1:0]    outData,
   output logic                 RdValid,
   input  logic                 RdReady,
   output logic                 WrDone,
   output logic                 AddrErr
);

   localparam int IDX_W = $clog2(DEPTH);

   state_e              state_q, state_d;
   logic                wr_done_q;
   logic                addr_err_q;
   logic                rd_err_q;
   logic                w_idle;
   logic                w_acc_wr;
   logic                w_acc_rd;
   logic                w_oor;
   logic                w_we;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_unused_addr;

   assign w_idle   = (state_q == IDLE);
   assign w_acc_wr = MemWrite & w_idle;
   assign w_acc_rd = MemRead  & w_idle;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
   // Any set bit above the word index means the address is beyond DEPTH
   generate
      if (ADDR_W > IDX_W) begin : g_range_chk
         assign w_oor = |Address[ADDR_W-1:IDX_W];
      end else begin : g_no_range_chk
         assign w_oor = 1'b0;
      end
   endgenerate
`else
   // Upper address bits are ignored: addresses wrap modulo DEPTH
   assign w_oor = 1'b0;
`endif

   assign w_unused_addr = ^Address;

   // Out-of-range writes still complete the handshake but leave memory untouched
   assign w_we = w_acc_wr & ~w_oor;

   data_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .we_i    (w_we),
      .be_i    (ByteEn),
      .addr_i  (Address[IDX_W-1:0]),
      .wdata_i (WriteData),
      .re_i    (w_acc_rd),
      .rdata_o (w_rdata)
   );

   // State register and one-cycle status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_done_q  <= 1'b0;
         addr_err_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_done_q  <= w_acc_wr;
         addr_err_q <= (w_acc_wr | w_acc_rd) & w_oor;
         if (w_acc_rd) begin
            rd_err_q <= w_oor;
         end
      end
   end

   // Next-state logic: read latency selects whether RD_WAIT is visited
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (w_acc_rd) begin
               state_d = (RD_LAT == 2) ? RD_WAIT : RD_RESP;
            end
         end
         RD_WAIT: state_d = RD_RESP;
         RD_RESP: begin
            if (RdReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ReqReady = w_idle;
   assign RdValid  = (state_q == RD_RESP);
   assign outData  = (RdValid && !rd_err_q) ? w_rdata : '0;
   assign WrDone   = wr_done_q;
   assign AddrErr  = addr_err_q;

endmodule : data_mem_ctrl
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl: directed scenarios plus
//               randomized read/write/read+write traffic against an array model.
//               Expectations follow DATA_MEM_BOUNDS_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 256;
   localparam int RD_LAT = 2;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   logic [1:0]        ByteEn;
   logic              ReqReady;
   logic [DATA_W-1:0] outData;
   logic              RdValid;
   logic              RdReady;
   logic              WrDone;
   logic              AddrErr;

   int n_checks;
   int n_errors;

   logic [15:0] mdl [DEPTH];

   data_mem_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ByteEn    (ByteEn),
      .ReqReady  (ReqReady),
      .outData   (outData),
      .RdValid   (RdValid),
      .RdReady   (RdReady),
      .WrDone    (WrDone),
      .AddrErr   (AddrErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it, report any mismatch
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_oor(input int addr);
      return BOUNDS && (addr >= DEPTH);
   endfunction

   // Reference write: byte-merge into the model unless the range check drops it
   task automatic model_write(input int addr, input logic [15:0] data, input logic [1:0] be);
      if (!is_oor(addr)) begin
         if (be[0]) mdl[addr % DEPTH][7:0]  = data[7:0];
         if (be[1]) mdl[addr % DEPTH][15:8] = data[15:8];
      end
   endtask

   // One request (read, write or both); reads are followed through to consumption
   task automatic do_access(input bit rd, input bit wr, input int addr,
                            input logic [15:0] data, input logic [1:0] be, input int stall);
      logic [15:0] exp_rd;
      MemRead   = rd;
      MemWrite  = wr;
      Address   = addr[ADDR_W-1:0];
      WriteData = data;
      ByteEn    = be;
      chk("req_ready_idle", ReqReady, 1);
      @(posedge clk); #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      if (wr) model_write(addr, data, be);
      exp_rd = is_oor(addr) ? 16'h0 : mdl[addr % DEPTH];
      chk("wr_done", WrDone, wr);
      chk("addr_err", AddrErr, is_oor(addr));
      if (rd) begin
         for (int k = 1; k < RD_LAT; k++) begin
            chk("rd_wait_valid", RdValid, 0);
            chk("rd_wait_data", outData, 0);
            chk("rd_wait_ready", ReqReady, 0);
            @(posedge clk); #1;
            chk("wr_done_clear", WrDone, 0);
         end
         chk("rd_valid", RdValid, 1);
         chk("rd_data", outData, exp_rd);
         chk("rd_busy", ReqReady, 0);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", RdValid, 1);
            chk("stall_data", outData, exp_rd);
            chk("stall_ready", ReqReady, 0);
         end
         RdReady = 1'b1;
         @(posedge clk); #1;
         RdReady = 1'b0;
         chk("post_rd_valid", RdValid, 0);
         chk("post_rd_data", outData, 0);
         chk("post_rd_idle", ReqReady, 1);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      ByteEn    = '0;
      RdReady   = 1'b0;

      // Reset values
      #12;
      chk("rst_rd_valid", RdValid, 0);
      chk("rst_out_data", outData, 0);
      chk("rst_wr_done", WrDone, 0);
      chk("rst_addr_err", AddrErr, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", ReqReady, 1);

      // Back-to-back preload of every word
      MemWrite = 1'b1;
      ByteEn   = 2'b11;
      for (int i = 0; i < DEPTH; i++) begin
         Address   = i[ADDR_W-1:0];
         WriteData = 16'($urandom);
         chk("b2b_ready", ReqReady, 1);
         @(posedge clk); #1;
         mdl[i] = WriteData;
         chk("b2b_wr_done", WrDone, 1);
      end
      MemWrite = 1'b0;
      @(posedge clk); #1;
      chk("wr_done_single", WrDone, 0);

      // Full write then read
      do_access(0, 1, 20, 16'h02AF, 2'b11, 0);
      do_access(1, 0, 20, 16'h0, 2'b00, 0);
      // Partial byte write
      do_access(0, 1, 20, 16'h1234, 2'b11, 0);
      do_access(0, 1, 20, 16'hABCD, 2'b01, 0);
      do_access(1, 0, 20, 16'h0, 2'b00, 0);
      chk("byte_merge_model", mdl[20], 16'h12CD);
      // Held response
      do_access(1, 0, 20, 16'h0, 2'b00, 5);
      // Write-first read
      do_access(1, 1, 7, 16'h5555, 2'b11, 0);
      // Empty byte enable
      do_access(0, 1, 9, 16'hFFFF, 2'b00, 0);
      do_access(1, 0, 9, 16'h0, 2'b00, 0);

      // Reset during the read wait: response is discarded
      do_access(0, 1, 33, 16'hC0DE, 2'b11, 0);
      MemRead = 1'b1;
      Address = 16'd33;
      @(posedge clk); #1;
      MemRead = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("rst_mid_valid", RdValid, 0);
      chk("rst_mid_data", outData, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rst_no_resp", RdValid, 0);
      end
      do_access(1, 0, 33, 16'h0, 2'b00, 0);

      // Out-of-range address aliases word 44 or is dropped
      do_access(0, 1, 44, 16'h4444, 2'b11, 0);
      do_access(0, 1, 300, 16'h9999, 2'b11, 0);
      do_access(1, 0, 44, 16'h0, 2'b00, 0);
      chk("oor_word44", mdl[44], BOUNDS ? 16'h4444 : 16'h9999);
      do_access(1, 0, 300, 16'h0, 2'b00, 1);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         do_access(kind != 0, kind != 1, int'($urandom_range(0, 511)),
                   16'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            chk("idle_wr_done", WrDone, 0);
            chk("idle_rd_valid", RdValid, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the bench always terminates
   initial begin
      #2000000;
      n_errors++;
      $display("FAIL timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_data_mem_ctrl
`default_nettype wire
